// File: rtl/gpcore_pkg.sv
// Shared core types and constants.
// Provides the NOP encoding and the fetch-entry bundle.
package gpcore_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {instr, pc}.
// Ports: i_push/i_data, i_pop, i_flush, o_head, o_count.
module fetch_fifo
  import gpcore_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full = (r_cnt == CW'(DEPTH));
  // a full buffer may still push when it pops
  assign w_push = i_push & ~i_flush & (~w_full | i_pop);
  assign w_pop  = i_pop & ~i_flush & (r_cnt != '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/instfetch_stage.sv
// Instruction fetch: PC, request credits, kill counter, buffer.
// Ports: imem req/rsp, redirect, instr/instr_pc/valid/ready.
module instfetch_stage
  import gpcore_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_rpc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_kill;

  logic [CW-1:0] w_cnt;
  logic [31:0]   w_tgt;
  logic          w_req_hs;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_in;
  fetch_entry_t  w_head;

  assign w_tgt = {redirect_pc[31:2], 2'b00};

  // outstanding + buffered never exceeds DEPTH,
  // so every response owns a slot
  assign imem_req_valid = nrst & ~redirect &
                          ((r_outst + w_cnt) < CW'(DEPTH));
  assign imem_addr = r_pc;
  assign w_req_hs  = imem_req_valid & imem_req_ready;

  // responses with nothing outstanding are dropped
  assign w_rsp  = imem_rsp_valid & (r_outst != '0);
  assign w_push = w_rsp & ~redirect & (r_kill == '0);
  assign w_pop  = instr_valid & instr_ready & ~redirect;

  // r_rpc: PC of the next response that survives the kill
  assign w_in = '{instr: imem_rsp_data, pc: r_rpc};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pc    <= RESET_PC;
      r_rpc   <= RESET_PC;
      r_outst <= '0;
      r_kill  <= '0;
    end else begin
      if (redirect)      r_pc <= w_tgt;
      else if (w_req_hs) r_pc <= r_pc + 32'd4;

      case ({w_req_hs, w_rsp})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase

      // r_outst already counts earlier kills,
      // so reloading it handles back-to-back redirects
      if (redirect)
        r_kill <= r_outst - CW'(w_rsp);
      else if (w_rsp && r_kill != '0)
        r_kill <= r_kill - CW'(1);

      if (redirect)    r_rpc <= w_tgt;
      else if (w_push) r_rpc <= r_rpc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_cnt)
  );

  assign instr_valid = (w_cnt != '0);
  assign instr    = instr_valid ? w_head.instr : NOP;
  assign instr_pc = instr_valid ? w_head.pc : 32'd0;

endmodule

// File: tb/tb_instfetch_stage.sv
// Scoreboard bench for instfetch_stage.
// Main DUT plus a second instance for PC wrap.
module tb_instfetch_stage;
  import gpcore_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic        wv;
  logic [31:0] wa;
  logic        wrv = 1'b0;
  logic [31:0] wrd = '0;
  logic [31:0] wi;
  logic [31:0] wipc;
  logic        wiv;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zpc = '0;

  always #5 clk = ~clk;

  instfetch_stage u_dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  instfetch_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_wrap (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (wv),
    .imem_req_ready (w_one),
    .imem_addr      (wa),
    .imem_rsp_valid (wrv),
    .imem_rsp_data  (wrd),
    .redirect       (w_zero),
    .redirect_pc    (w_zpc),
    .instr          (wi),
    .instr_pc       (wipc),
    .instr_valid    (wiv),
    .instr_ready    (w_one)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       memq[$];
  logic [31:0] hs_log[$];
  logic [31:0] expq[$];
  logic [31:0] wlog[$];

  int          total = 0;
  int          bad = 0;
  int          ndel = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          mem_on = 1'b1;
  logic        hs_n = 1'b0;
  logic [31:0] a_n = '0;
  logic        w_hs_n = 1'b0;
  logic [31:0] w_a_n = '0;
  bit          w_got = 1'b0;
  logic [31:0] w_first = '0;
  logic [31:0] e;
  pend_t       p;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // memory model: fixed latency, in-order
  always @(negedge clk) begin
    hs_n = nrst & imem_req_valid & imem_req_ready;
    a_n  = imem_addr;
  end

  always @(posedge clk) begin
    cyc++;
    if (hs_n) begin
      p.addr = a_n;
      p.due  = cyc + lat - 1;
      memq.push_back(p);
      hs_log.push_back(a_n);
    end
    #1;
    if (mem_on) begin
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = f(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // monitor: pop expectation on every delivered instruction
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (instr_valid && instr_ready && !redirect) begin
        ndel++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected actual_pc=%h required=none",
                   instr_pc);
        end else begin
          e = expq.pop_front();
          chk("pc", instr_pc, e);
          chk("instr", instr, f(e));
        end
      end else if (!instr_valid) begin
        chk("idle_instr", instr, NOP);
        chk("idle_pc", instr_pc, 32'd0);
      end
    end
  end

  // wrap instance: always-ready 1-cycle memory
  always @(negedge clk) begin
    w_hs_n = nrst & wv;
    w_a_n  = wa;
    if (nrst && wiv && !w_got) begin
      w_got   = 1'b1;
      w_first = wipc;
    end
  end

  always @(posedge clk) begin
    #1;
    wrv = w_hs_n;
    wrd = f(w_a_n);
    if (w_hs_n && wlog.size() < 3) wlog.push_back(w_a_n);
  end

  task automatic push_seq(input logic [31:0] base,
                          input int n);
    for (int i = 0; i < n; i++)
      expq.push_back(base + 32'(4 * i));
  endtask

  task automatic accept(input int n);
    int tgt;
    int t;
    tgt = ndel + n;
    t = 0;
    instr_ready = 1'b1;
    while (ndel < tgt && t < 200) begin
      @(posedge clk);
      t++;
    end
    #2;
    instr_ready = 1'b0;
    chk("deliveries", 32'(ndel), 32'(tgt));
    chk("expq_empty", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  // entered at posedge+2; leaves in cycle 0 after release
  task automatic do_reset(input logic rdy);
    nrst = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    mem_on = 1'b1;
    memq.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'd0);
    memq.delete();
    hs_log.delete();
    imem_req_ready = rdy;
    nrst = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nrst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    @(posedge clk);
    #2;

    // first fetch and latency
    lat = 1;
    do_reset(1'b1);
    @(negedge clk);
    chk("lat_c0", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("lat_c1", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(instr_valid), 32'd1);
    push_seq(32'h0, 6);
    accept(6);
    chk("addr0", hs_log[0], 32'h0);
    chk("addr1", hs_log[1], 32'h4);
    chk("addr2", hs_log[2], 32'h8);

    // backpressure
    lat = 1;
    do_reset(1'b1);
    repeat (10) @(posedge clk);
    #2;
    chk("bp_reqs", 32'(hs_log.size()), 32'd2);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head", instr_pc, 32'h0);
    push_seq(32'h0, 8);
    accept(8);

    // redirect with two outstanding
    lat = 3;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    chk("rd_credit", 32'(imem_req_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    next_cyc();
    redirect = 1'b0;
    chk("rd_addr", imem_addr, 32'h0000_0100);
    chk("rd_valid", 32'(instr_valid), 32'd0);
    push_seq(32'h100, 3);
    accept(3);
    chk("rd_first_hs", hs_log[2], 32'h0000_0100);

    // redirect + response + pop in one cycle
    lat = 1;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    chk("same_head", instr_pc, 32'h0);
    chk("same_rsp", 32'(imem_rsp_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1'b1;
    next_cyc();
    redirect = 1'b0;
    instr_ready = 1'b0;
    chk("same_flush", 32'(instr_valid), 32'd0);
    chk("same_nop", instr, NOP);
    push_seq(32'h200, 3);
    accept(3);

    // back-to-back redirects
    lat = 3;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    next_cyc();
    redirect_pc = 32'h0000_0400;
    next_cyc();
    redirect = 1'b0;
    chk("b2b_addr", imem_addr, 32'h0000_0400);
    push_seq(32'h400, 3);
    accept(3);

    // reset mid-stream, stale response after release
    lat = 1;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    chk("ms_valid", 32'(instr_valid), 32'd1);
    mem_on = 1'b0;
    nrst = 1'b0;
    #1;
    chk("ms_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ms_instr_valid", 32'(instr_valid), 32'd0);
    chk("ms_instr", instr, NOP);
    chk("ms_instr_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    memq.delete();
    hs_log.delete();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    nrst = 1'b1;
    next_cyc();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    mem_on = 1'b1;
    push_seq(32'h0, 3);
    accept(3);
    chk("ms_first_hs", hs_log[0], 32'h0);

    // wrap instance
    chk("wrap_n", 32'(wlog.size()), 32'd3);
    chk("wrap0", wlog[0], 32'hFFFF_FFF8);
    chk("wrap1", wlog[1], 32'hFFFF_FFFC);
    chk("wrap2", wlog[2], 32'h0000_0000);
    chk("wrap_first_pc", w_first, 32'hFFFF_FFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
